// File: rtl/lcd_char_sink.sv
// Character-LCD sink model: decodes LCD bus transfers, keeps DDRAM, the address counter and display state, and scans the screen.
// Optional busy emulation after clear/return-home is enabled with LCD_SINK_BUSY_EN.
module lcd_char_sink #(
  parameter int BUSY_CYCLES = 30
) (
  input  logic       CLK,
  input  logic       RESETN,
  input  logic       LCD_E,
  input  logic       LCD_RS,
  input  logic       LCD_RW,
  input  logic [7:0] LCD_DATA,
  output logic [7:0] RD_DATA,
  input  logic [4:0] SCR_ADDR,
  output logic [7:0] SCR_CHAR,
  output logic [6:0] AC,
  output logic       DISP_ON,
  output logic       CURSOR_ON,
  output logic       BLINK_ON,
  output logic       TWO_LINE,
  output logic       BUSY,
  output logic [15:0] WR_CNT,
  output logic       ERR
);

  localparam logic [7:0] SPACE = 8'h20;

  logic [7:0]  ddram [80];
  logic [6:0]  ac_q, ac_d;
  logic        id_q, id_d;
  logic        disp_q, disp_d;
  logic        cursor_q, cursor_d;
  logic        blink_q, blink_d;
  logic        two_line_q, two_line_d;
  logic        err_q, err_d;
  logic [15:0] wr_cnt_q, wr_cnt_d;
  logic [7:0]  rd_q, rd_d;
  logic [7:0]  scr_q;
  logic        busy;
  logic        busy_start;
  logic        clear_all;
  logic        ddram_we;
  logic        wr_ok;

  // Line 1 (0x40-0x67) is packed directly after line 0 (0x00-0x27).
  function automatic logic [6:0] ddram_idx(input logic [6:0] a);
    if (a[6])
      return 7'd40 + {1'b0, a[5:0]};
    else
      return {1'b0, a[5:0]};
  endfunction

  function automatic logic [6:0] ac_step(input logic [6:0] a, input logic inc);
    logic [6:0] r;
    if (inc) begin
      if (a == 7'h27)      r = 7'h40;
      else if (a == 7'h67) r = 7'h00;
      else                 r = a + 7'd1;
    end else begin
      if (a == 7'h00)      r = 7'h67;
      else if (a == 7'h40) r = 7'h27;
      else                 r = a - 7'd1;
    end
    return r;
  endfunction

  assign wr_ok = LCD_E && !LCD_RW && !busy;

  always_comb begin
    ac_d       = ac_q;
    id_d       = id_q;
    disp_d     = disp_q;
    cursor_d   = cursor_q;
    blink_d    = blink_q;
    two_line_d = two_line_q;
    err_d      = err_q;
    wr_cnt_d   = wr_cnt_q;
    rd_d       = rd_q;
    busy_start = 1'b0;
    clear_all  = 1'b0;
    ddram_we   = 1'b0;

    if (LCD_E && !LCD_RW && busy)
      err_d = 1'b1;

    if (wr_ok && !LCD_RS) begin
      casez (LCD_DATA)
        8'b1???????: begin
          // Gap addresses between/after the two lines are rejected.
          if (LCD_DATA[5:0] >= 6'h28)
            err_d = 1'b1;
          else
            ac_d = LCD_DATA[6:0];
        end
        8'b01??????: ;
        8'b001?????: two_line_d = LCD_DATA[3];
        8'b0001????: begin
          if (!LCD_DATA[3])
            ac_d = ac_step(ac_q, LCD_DATA[2]);
        end
        8'b00001???: begin
          disp_d   = LCD_DATA[2];
          cursor_d = LCD_DATA[1];
          blink_d  = LCD_DATA[0];
        end
        8'b000001??: id_d = LCD_DATA[1];
        8'b0000001?: begin
          ac_d       = 7'h00;
          busy_start = 1'b1;
        end
        8'b00000001: begin
          ac_d       = 7'h00;
          id_d       = 1'b1;
          clear_all  = 1'b1;
          busy_start = 1'b1;
        end
        default: ;
      endcase
    end

    if (wr_ok && LCD_RS) begin
      ddram_we = 1'b1;
      ac_d     = ac_step(ac_q, id_q);
      wr_cnt_d = wr_cnt_q + 16'd1;
    end

    if (LCD_E && LCD_RW) begin
      if (!LCD_RS) begin
        rd_d = {busy, ac_q};
      end else begin
        rd_d = ddram[ddram_idx(ac_q)];
        ac_d = ac_step(ac_q, id_q);
      end
    end
  end

  always_ff @(posedge CLK or negedge RESETN) begin
    if (!RESETN) begin
      ac_q       <= 7'h00;
      id_q       <= 1'b1;
      disp_q     <= 1'b0;
      cursor_q   <= 1'b0;
      blink_q    <= 1'b0;
      two_line_q <= 1'b0;
      err_q      <= 1'b0;
      wr_cnt_q   <= 16'h0000;
      rd_q       <= 8'h00;
      scr_q      <= SPACE;
    end else begin
      ac_q       <= ac_d;
      id_q       <= id_d;
      disp_q     <= disp_d;
      cursor_q   <= cursor_d;
      blink_q    <= blink_d;
      two_line_q <= two_line_d;
      err_q      <= err_d;
      wr_cnt_q   <= wr_cnt_d;
      rd_q       <= rd_d;
      // Scan uses pre-edge memory and display state: one cycle of latency.
      scr_q      <= disp_q ? ddram[ddram_idx({SCR_ADDR[4], 2'b00, SCR_ADDR[3:0]})] : SPACE;
    end
  end

  always_ff @(posedge CLK or negedge RESETN) begin
    if (!RESETN) begin
      for (int i = 0; i < 80; i++)
        ddram[i] <= SPACE;
    end else if (clear_all) begin
      for (int i = 0; i < 80; i++)
        ddram[i] <= SPACE;
    end else if (ddram_we) begin
      ddram[ddram_idx(ac_q)] <= LCD_DATA;
    end
  end

`ifdef LCD_SINK_BUSY_EN
  logic [15:0] busy_cnt;

  always_ff @(posedge CLK or negedge RESETN) begin
    if (!RESETN)
      busy_cnt <= 16'd0;
    else if (busy_start)
      busy_cnt <= 16'(BUSY_CYCLES);
    else if (busy_cnt != 16'd0)
      busy_cnt <= busy_cnt - 16'd1;
  end

  assign busy = (busy_cnt != 16'd0);
`else
  logic unused_busy;

  assign busy        = 1'b0;
  assign unused_busy = busy_start ^ (BUSY_CYCLES == 0);
`endif

  assign RD_DATA   = rd_q;
  assign SCR_CHAR  = scr_q;
  assign AC        = ac_q;
  assign DISP_ON   = disp_q;
  assign CURSOR_ON = cursor_q;
  assign BLINK_ON  = blink_q;
  assign TWO_LINE  = two_line_q;
  assign BUSY      = busy;
  assign WR_CNT    = wr_cnt_q;
  assign ERR       = err_q;

endmodule

// File: tb/tb_lcd_char_sink.sv
// Directed bench for lcd_char_sink; expected values are hand-computed.
// Busy-path steps are selected with LCD_SINK_BUSY_EN to match the DUT build.
module tb_lcd_char_sink;

  logic        CLK;
  logic        RESETN;
  logic        LCD_E;
  logic        LCD_RS;
  logic        LCD_RW;
  logic [7:0]  LCD_DATA;
  logic [7:0]  RD_DATA;
  logic [4:0]  SCR_ADDR;
  logic [7:0]  SCR_CHAR;
  logic [6:0]  AC;
  logic        DISP_ON;
  logic        CURSOR_ON;
  logic        BLINK_ON;
  logic        TWO_LINE;
  logic        BUSY;
  logic [15:0] WR_CNT;
  logic        ERR;

  int total = 0;
  int bad   = 0;

  lcd_char_sink #(.BUSY_CYCLES(30)) dut (
    .CLK(CLK), .RESETN(RESETN), .LCD_E(LCD_E), .LCD_RS(LCD_RS), .LCD_RW(LCD_RW),
    .LCD_DATA(LCD_DATA), .RD_DATA(RD_DATA), .SCR_ADDR(SCR_ADDR), .SCR_CHAR(SCR_CHAR),
    .AC(AC), .DISP_ON(DISP_ON), .CURSOR_ON(CURSOR_ON), .BLINK_ON(BLINK_ON),
    .TWO_LINE(TWO_LINE), .BUSY(BUSY), .WR_CNT(WR_CNT), .ERR(ERR)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic xfer(input logic rs, input logic rw, input logic [7:0] d);
    @(negedge CLK);
    LCD_E    = 1'b1;
    LCD_RS   = rs;
    LCD_RW   = rw;
    LCD_DATA = d;
    @(posedge CLK);
    #1;
    LCD_E = 1'b0;
  endtask

  task automatic instr(input logic [7:0] d);
    xfer(1'b0, 1'b0, d);
  endtask

  task automatic wdata(input logic [7:0] d);
    xfer(1'b1, 1'b0, d);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge CLK);
      #1;
    end
  endtask

  initial begin
    RESETN   = 1'b0;
    LCD_E    = 1'b0;
    LCD_RS   = 1'b0;
    LCD_RW   = 1'b0;
    LCD_DATA = 8'h00;
    SCR_ADDR = 5'h00;
    idle(2);
    @(negedge CLK);
    RESETN = 1'b1;
    idle(1);

    check("rst_scr", 16'(SCR_CHAR), 16'h20);
    check("rst_ac", 16'(AC), 16'h00);
    check("rst_wrcnt", WR_CNT, 16'h0);
    check("rst_err", 16'(ERR), 16'h0);
    check("rst_rd", 16'(RD_DATA), 16'h00);
    check("rst_disp", 16'({DISP_ON, CURSOR_ON, BLINK_ON, TWO_LINE, BUSY}), 16'h0);

    instr(8'h3C);
    check("two_line", 16'(TWO_LINE), 16'h1);
    instr(8'h0C);
    check("disp_dcb", 16'({DISP_ON, CURSOR_ON, BLINK_ON}), 16'b100);
    instr(8'h06);
    instr(8'h80);
    SCR_ADDR = 5'h02;
    wdata("T");
    wdata("I");
    wdata("M");
    check("scr_latency", 16'(SCR_CHAR), 16'h20);
    wdata("E");
    check("scr_m", 16'(SCR_CHAR), 16'h4D);
    check("time_ac", 16'(AC), 16'h04);
    check("time_wrcnt", WR_CNT, 16'd4);

    instr(8'hA7);
    wdata("A");
    check("wrap_27_40", 16'(AC), 16'h40);
    wdata("B");
    check("wrap_ac41", 16'(AC), 16'h41);
    instr(8'hA7);
    xfer(1'b1, 1'b1, 8'h00);
    check("rd_27", 16'(RD_DATA), 16'h41);
    check("rd_27_ac", 16'(AC), 16'h40);
    xfer(1'b1, 1'b1, 8'h00);
    check("rd_40", 16'(RD_DATA), 16'h42);

    instr(8'h80);
    instr(8'h04);
    wdata("Z");
    check("wrap_00_67", 16'(AC), 16'h67);
    instr(8'hC0);
    xfer(1'b1, 1'b1, 8'h00);
    check("dec_rd_40", 16'(RD_DATA), 16'h42);
    check("wrap_40_27", 16'(AC), 16'h27);
    instr(8'h06);
    instr(8'h14);
    check("cur_right", 16'(AC), 16'h40);
    instr(8'h10);
    check("cur_left", 16'(AC), 16'h27);
    instr(8'h18);
    check("disp_shift_ign", 16'(AC), 16'h27);

    instr(8'hA8);
    check("bad_addr_err", 16'(ERR), 16'h1);
    check("bad_addr_ac", 16'(AC), 16'h27);

    SCR_ADDR = 5'h01;
    idle(2);
    check("scr_i", 16'(SCR_CHAR), 16'h49);
    instr(8'h08);
    idle(1);
    check("disp_off_scr", 16'(SCR_CHAR), 16'h20);
    instr(8'h0F);
    check("cur_blink_on", 16'({DISP_ON, CURSOR_ON, BLINK_ON}), 16'b111);
    SCR_ADDR = 5'h10;
    idle(2);
    check("scr_line1", 16'(SCR_CHAR), 16'h42);

    instr(8'hC5);
    wdata("O");
    check("o_ac", 16'(AC), 16'h46);
    check("o_wrcnt", WR_CNT, 16'd8);
    instr(8'hC5);
    xfer(1'b1, 1'b1, 8'h00);
    check("rd_o", 16'(RD_DATA), 16'h4F);
    check("rd_o_ac", 16'(AC), 16'h46);
    xfer(1'b0, 1'b1, 8'h00);
    check("status", 16'(RD_DATA), 16'h46);
    check("err_sticky", 16'(ERR), 16'h1);

    @(negedge CLK);
    RESETN = 1'b0;
    #1;
    check("mid_rst_ac", 16'(AC), 16'h00);
    check("mid_rst_err", 16'(ERR), 16'h0);
    check("mid_rst_wrcnt", WR_CNT, 16'h0);
    check("mid_rst_scr", 16'(SCR_CHAR), 16'h20);
    check("mid_rst_disp", 16'({DISP_ON, TWO_LINE}), 16'h0);
    @(negedge CLK);
    RESETN = 1'b1;
    instr(8'h85);
    check("post_rst_ac", 16'(AC), 16'h05);
    instr(8'h0C);

`ifdef LCD_SINK_BUSY_EN
    instr(8'h01);
    wdata("Q");
    check("busy_set", 16'(BUSY), 16'h1);
    check("busy_drop_cnt", WR_CNT, 16'h0);
    check("busy_drop_ac", 16'(AC), 16'h00);
    check("busy_err", 16'(ERR), 16'h1);
    xfer(1'b0, 1'b1, 8'h00);
    check("busy_status", 16'(RD_DATA), 16'h80);
    idle(27);
    check("busy_still", 16'(BUSY), 16'h1);
    idle(1);
    check("busy_done", 16'(BUSY), 16'h0);
`else
    instr(8'h80);
    wdata("K");
    SCR_ADDR = 5'h00;
    idle(1);
    check("scr_k", 16'(SCR_CHAR), 16'h4B);
    instr(8'h02);
    check("home_ac", 16'(AC), 16'h00);
    check("home_busy", 16'(BUSY), 16'h0);
    instr(8'h04);
    instr(8'h01);
    idle(1);
    check("clear_scr", 16'(SCR_CHAR), 16'h20);
    wdata("Q");
    check("clear_id", 16'(AC), 16'h01);
    check("clear_wrcnt", WR_CNT, 16'd2);
    check("clear_err", 16'(ERR), 16'h0);
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
